// File: rtl/trig_pkg.sv
// Shared types, default window values and {max,min} field helpers for the
// trig_window_ctrl trigger sequencer.
package trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_L1 = 2'd1,
    ST_WAIT_L2 = 2'd2
  } trig_state_e;

  localparam logic [15:0] L1_MIN_DEF = 16'd120;
  localparam logic [15:0] L1_MAX_DEF = 16'd300;
  localparam logic [15:0] L2_MIN_DEF = 16'd200;
  localparam logic [15:0] L2_MAX_DEF = 16'd20000;

  // Helpers accept any field width up to TW_MAX_W; callers zero-extend the packed pair.
  localparam int unsigned TW_MAX_W = 32;
  localparam int unsigned TW2_W    = 2 * TW_MAX_W;

  function automatic logic [TW_MAX_W-1:0] tw_min(input logic [TW2_W-1:0] tw, input int unsigned w);
    logic [TW2_W-1:0] mask;
    mask = {TW2_W{1'b1}} >> (TW2_W - w);
    return TW_MAX_W'(tw & mask);
  endfunction

  function automatic logic [TW_MAX_W-1:0] tw_max(input logic [TW2_W-1:0] tw, input int unsigned w);
    logic [TW2_W-1:0] mask;
    mask = {TW2_W{1'b1}} >> (TW2_W - w);
    return TW_MAX_W'((tw >> w) & mask);
  endfunction

endpackage

// File: rtl/trig_window_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise increment until saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {W{1'b0}};
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/trig_window_ctrl.sv
// L0/L1/L2 trigger sequencer: qualifies each trigger against programmable
// time windows and reports accepted pulses, busy, event and error counts.
module trig_window_ctrl
  import trig_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ERR_W = 16,
  parameter int unsigned EVT_W = 24
) (
  input  logic               gclk_40m,
  input  logic               reset,
  input  logic               l0_in,
  input  logic               l1_in,
  input  logic               l2a_in,
  input  logic               l2r_in,
  input  logic               evcnt_res,
  input  logic               ext_busy,
  input  logic [2*CNT_W-1:0] l1_tw,
  input  logic [2*CNT_W-1:0] l2_tw,
  output logic               l0_out,
  output logic               l1_out,
  output logic               l2a_out,
  output logic               l2r_out,
  output logic               trig_busy,
  output logic [EVT_W-1:0]   evt_cnt,
  output logic [ERR_W-1:0]   l1_err_cnt,
  output logic [ERR_W-1:0]   l2_err_cnt,
  output logic [ERR_W-1:0]   spur_cnt
);

  localparam logic [CNT_W-1:0] TIMER_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [EVT_W-1:0] EVT_ONE   = {{(EVT_W-1){1'b0}}, 1'b1};

  trig_state_e      state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] win_min_q, win_min_d;
  logic [CNT_W-1:0] win_max_q, win_max_d;
  logic             l0_out_q, l0_out_d;
  logic             l1_out_q, l1_out_d;
  logic             l2a_out_q, l2a_out_d;
  logic             l2r_out_q, l2r_out_d;
  logic             trig_busy_q, trig_busy_d;
  logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;

  logic [CNT_W-1:0] l1_min_s, l1_max_s, l2_min_s, l2_max_s;
  logic             in_win_s, timeout_s;
  logic             l1_err_inc_s, l2_err_inc_s, spur_inc_s, evt_inc_s;

  assign l1_min_s  = CNT_W'(tw_min(TW2_W'(l1_tw), CNT_W));
  assign l1_max_s  = CNT_W'(tw_max(TW2_W'(l1_tw), CNT_W));
  assign l2_min_s  = CNT_W'(tw_min(TW2_W'(l2_tw), CNT_W));
  assign l2_max_s  = CNT_W'(tw_max(TW2_W'(l2_tw), CNT_W));
  // With min>max no timer value satisfies both bounds, so every arrival is an error.
  assign in_win_s  = (timer_q >= win_min_q) && (timer_q <= win_max_q);
  assign timeout_s = (timer_q >= win_max_q);

  // Next-state, window capture, output pulses and counter increments.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    win_min_d    = win_min_q;
    win_max_d    = win_max_q;
    l0_out_d     = 1'b0;
    l1_out_d     = 1'b0;
    l2a_out_d    = 1'b0;
    l2r_out_d    = 1'b0;
    l1_err_inc_s = 1'b0;
    l2_err_inc_s = 1'b0;
    spur_inc_s   = 1'b0;
    evt_inc_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d    = {CNT_W{1'b0}};
        spur_inc_s = (l0_in && ext_busy) || l1_in || l2a_in || l2r_in;
        if (l0_in && !ext_busy) begin
          l0_out_d  = 1'b1;
          state_d   = ST_WAIT_L1;
          timer_d   = TIMER_ONE;
          win_min_d = l1_min_s;
          win_max_d = l1_max_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_L1: begin
        timer_d    = timer_q + TIMER_ONE;
        spur_inc_s = l0_in || l2a_in || l2r_in;
        if (l1_in && in_win_s) begin
          l1_out_d  = 1'b1;
          state_d   = ST_WAIT_L2;
          timer_d   = TIMER_ONE;
          win_min_d = l2_min_s;
          win_max_d = l2_max_s;
        end else if (l1_in || timeout_s) begin
          l1_err_inc_s = 1'b1;
          state_d      = ST_IDLE;
          timer_d      = {CNT_W{1'b0}};
        end else begin
          state_d = ST_WAIT_L1;
        end
      end
      ST_WAIT_L2: begin
        timer_d    = timer_q + TIMER_ONE;
        spur_inc_s = l0_in || l1_in;
        if (l2a_in && l2r_in) begin
          l2r_out_d    = 1'b1;
          l2_err_inc_s = 1'b1;
          state_d      = ST_IDLE;
          timer_d      = {CNT_W{1'b0}};
        end else if ((l2a_in || l2r_in) && in_win_s) begin
          l2a_out_d = l2a_in;
          l2r_out_d = l2r_in;
          evt_inc_s = l2a_in;
          state_d   = ST_IDLE;
          timer_d   = {CNT_W{1'b0}};
        end else if (l2a_in || l2r_in || timeout_s) begin
          // Early arrival or timeout: reject so the FEE buffers are released.
          l2r_out_d    = 1'b1;
          l2_err_inc_s = 1'b1;
          state_d      = ST_IDLE;
          timer_d      = {CNT_W{1'b0}};
        end else begin
          state_d = ST_WAIT_L2;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = {CNT_W{1'b0}};
      end
    endcase

    trig_busy_d = (state_d != ST_IDLE) || ext_busy;

    if (evcnt_res) begin
      evt_cnt_d = evt_inc_s ? EVT_ONE : {EVT_W{1'b0}};
    end else if (evt_inc_s) begin
      evt_cnt_d = evt_cnt_q + EVT_ONE;
    end else begin
      evt_cnt_d = evt_cnt_q;
    end
  end

  // State, timer, captured window and registered outputs.
  always_ff @(posedge gclk_40m) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= {CNT_W{1'b0}};
      win_min_q   <= {CNT_W{1'b0}};
      win_max_q   <= {CNT_W{1'b0}};
      l0_out_q    <= 1'b0;
      l1_out_q    <= 1'b0;
      l2a_out_q   <= 1'b0;
      l2r_out_q   <= 1'b0;
      trig_busy_q <= 1'b0;
      evt_cnt_q   <= {EVT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      win_min_q   <= win_min_d;
      win_max_q   <= win_max_d;
      l0_out_q    <= l0_out_d;
      l1_out_q    <= l1_out_d;
      l2a_out_q   <= l2a_out_d;
      l2r_out_q   <= l2r_out_d;
      trig_busy_q <= trig_busy_d;
      evt_cnt_q   <= evt_cnt_d;
    end
  end

  sat_counter #(.W(ERR_W)) u_l1_err (
    .clk(gclk_40m), .reset(reset), .clr(1'b0), .inc(l1_err_inc_s), .cnt(l1_err_cnt)
  );
  sat_counter #(.W(ERR_W)) u_l2_err (
    .clk(gclk_40m), .reset(reset), .clr(1'b0), .inc(l2_err_inc_s), .cnt(l2_err_cnt)
  );
  sat_counter #(.W(ERR_W)) u_spur (
    .clk(gclk_40m), .reset(reset), .clr(1'b0), .inc(spur_inc_s), .cnt(spur_cnt)
  );

  assign l0_out    = l0_out_q;
  assign l1_out    = l1_out_q;
  assign l2a_out   = l2a_out_q;
  assign l2r_out   = l2r_out_q;
  assign trig_busy = trig_busy_q;
  assign evt_cnt   = evt_cnt_q;

endmodule

// File: tb/tb_trig_window_ctrl.sv
// Directed self-checking bench for trig_window_ctrl: windows, timeouts,
// spurious triggers, event counter wrap/reset and mid-sequence reset.
module tb_trig_window_ctrl;

  logic        gclk_40m = 1'b0;
  logic        reset = 1'b1;
  logic        l0_in = 1'b0, l1_in = 1'b0, l2a_in = 1'b0, l2r_in = 1'b0;
  logic        evcnt_res = 1'b0, ext_busy = 1'b0;
  logic [31:0] l1_tw, l2_tw;
  logic        l0_out, l1_out, l2a_out, l2r_out, trig_busy;
  logic [23:0] evt_cnt;
  logic [15:0] l1_err_cnt, l2_err_cnt, spur_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  trig_window_ctrl #(.CNT_W(16), .ERR_W(16), .EVT_W(24)) dut (
    .gclk_40m(gclk_40m), .reset(reset), .l0_in(l0_in), .l1_in(l1_in),
    .l2a_in(l2a_in), .l2r_in(l2r_in), .evcnt_res(evcnt_res), .ext_busy(ext_busy),
    .l1_tw(l1_tw), .l2_tw(l2_tw), .l0_out(l0_out), .l1_out(l1_out),
    .l2a_out(l2a_out), .l2r_out(l2r_out), .trig_busy(trig_busy), .evt_cnt(evt_cnt),
    .l1_err_cnt(l1_err_cnt), .l2_err_cnt(l2_err_cnt), .spur_cnt(spur_cnt)
  );

  always #5 gclk_40m = ~gclk_40m;

  task automatic cyc(input int n);
    repeat (n) @(negedge gclk_40m);
  endtask

  // Drive a one-cycle pulse on {l0,l1,l2a,l2r,evcnt_res}; returns at the negedge where outputs show the result.
  task automatic pulse(input logic [4:0] m);
    {l0_in, l1_in, l2a_in, l2r_in, evcnt_res} = m;
    cyc(1);
    {l0_in, l1_in, l2a_in, l2r_in, evcnt_res} = 5'b00000;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    l1_tw = {16'd300, 16'd120};
    l2_tw = {16'd20000, 16'd200};
    cyc(3);
    n_cmp++; if ({l0_out, l1_out, l2a_out, l2r_out, trig_busy} !== 5'b00000) begin n_bad++; $display("FAIL reset_pulses: got %b want 00000", {l0_out, l1_out, l2a_out, l2r_out, trig_busy}); end
    n_cmp++; if (evt_cnt !== 24'd0) begin n_bad++; $display("FAIL reset_evt: got %0d want 0", evt_cnt); end
    n_cmp++; if ({l1_err_cnt, l2_err_cnt, spur_cnt} !== 48'd0) begin n_bad++; $display("FAIL reset_errs: got %h want 0", {l1_err_cnt, l2_err_cnt, spur_cnt}); end
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_nominal;
    pulse(5'b10000);
    n_cmp++; if (l0_out !== 1'b1) begin n_bad++; $display("FAIL nom_l0_out: got %b want 1", l0_out); end
    n_cmp++; if (trig_busy !== 1'b1) begin n_bad++; $display("FAIL nom_busy: got %b want 1", trig_busy); end
    cyc(1);
    n_cmp++; if (l0_out !== 1'b0) begin n_bad++; $display("FAIL nom_l0_width: got %b want 0", l0_out); end
    cyc(148);
    pulse(5'b01000);
    n_cmp++; if (l1_out !== 1'b1) begin n_bad++; $display("FAIL nom_l1_out: got %b want 1", l1_out); end
    cyc(1);
    n_cmp++; if (l1_out !== 1'b0) begin n_bad++; $display("FAIL nom_l1_width: got %b want 0", l1_out); end
    cyc(998);
    pulse(5'b00100);
    n_cmp++; if ({l2a_out, l2r_out} !== 2'b10) begin n_bad++; $display("FAIL nom_l2a_out: got %b want 10", {l2a_out, l2r_out}); end
    n_cmp++; if (evt_cnt !== 24'd1) begin n_bad++; $display("FAIL nom_evt: got %0d want 1", evt_cnt); end
    n_cmp++; if (trig_busy !== 1'b0) begin n_bad++; $display("FAIL nom_busy_end: got %b want 0", trig_busy); end
    n_cmp++; if ({l1_err_cnt, l2_err_cnt, spur_cnt} !== 48'd0) begin n_bad++; $display("FAIL nom_errs: got %h want 0", {l1_err_cnt, l2_err_cnt, spur_cnt}); end
    cyc(1);
    n_cmp++; if (l2a_out !== 1'b0) begin n_bad++; $display("FAIL nom_l2a_width: got %b want 0", l2a_out); end
  endtask

  task automatic test_l1_early;
    pulse(5'b10000);
    cyc(49);
    pulse(5'b01000);
    n_cmp++; if (l1_out !== 1'b0) begin n_bad++; $display("FAIL early_l1_out: got %b want 0", l1_out); end
    n_cmp++; if (l1_err_cnt !== 16'd1) begin n_bad++; $display("FAIL early_l1_err: got %0d want 1", l1_err_cnt); end
    n_cmp++; if (trig_busy !== 1'b0) begin n_bad++; $display("FAIL early_busy: got %b want 0", trig_busy); end
    cyc(2);
  endtask

  task automatic test_l1_timeout;
    pulse(5'b10000);
    cyc(299);
    n_cmp++; if ({trig_busy, l1_err_cnt} !== {1'b1, 16'd1}) begin n_bad++; $display("FAIL to1_before: got busy=%b err=%0d want 1/1", trig_busy, l1_err_cnt); end
    cyc(1);
    n_cmp++; if ({trig_busy, l1_err_cnt} !== {1'b0, 16'd2}) begin n_bad++; $display("FAIL to1_after: got busy=%b err=%0d want 0/2", trig_busy, l1_err_cnt); end
    cyc(2);
  endtask

  task automatic test_l2_timeout;
    pulse(5'b10000);
    cyc(149);
    pulse(5'b01000);
    n_cmp++; if (l1_out !== 1'b1) begin n_bad++; $display("FAIL to2_l1_out: got %b want 1", l1_out); end
    cyc(19999);
    n_cmp++; if ({trig_busy, l2r_out} !== 2'b10) begin n_bad++; $display("FAIL to2_before: got %b want 10", {trig_busy, l2r_out}); end
    cyc(1);
    n_cmp++; if ({trig_busy, l2a_out, l2r_out} !== 3'b001) begin n_bad++; $display("FAIL to2_l2r: got %b want 001", {trig_busy, l2a_out, l2r_out}); end
    n_cmp++; if (l2_err_cnt !== 16'd1) begin n_bad++; $display("FAIL to2_err: got %0d want 1", l2_err_cnt); end
    cyc(2);
  endtask

  task automatic test_window_edges;
    pulse(5'b10000);
    cyc(299);
    pulse(5'b01000);
    n_cmp++; if ({l1_out, l1_err_cnt} !== {1'b1, 16'd2}) begin n_bad++; $display("FAIL edge_l1_at_max: got out=%b err=%0d want 1/2", l1_out, l1_err_cnt); end
    cyc(199);
    pulse(5'b00010);
    n_cmp++; if ({l2a_out, l2r_out, l2_err_cnt} !== {2'b01, 16'd1}) begin n_bad++; $display("FAIL edge_l2r_at_min: got %b/%0d want 01/1", {l2a_out, l2r_out}, l2_err_cnt); end
    n_cmp++; if (evt_cnt !== 24'd1) begin n_bad++; $display("FAIL edge_evt: got %0d want 1", evt_cnt); end
    cyc(2);
  endtask

  task automatic test_simultaneous;
    pulse(5'b10000);
    cyc(149);
    pulse(5'b11000);
    n_cmp++; if ({l0_out, l1_out, spur_cnt} !== {2'b01, 16'd1}) begin n_bad++; $display("FAIL sim_l1_l0: got %b/%0d want 01/1", {l0_out, l1_out}, spur_cnt); end
    cyc(299);
    pulse(5'b00110);
    n_cmp++; if ({l2a_out, l2r_out} !== 2'b01) begin n_bad++; $display("FAIL sim_l2ar_out: got %b want 01", {l2a_out, l2r_out}); end
    n_cmp++; if ({l2_err_cnt, evt_cnt} !== {16'd2, 24'd1}) begin n_bad++; $display("FAIL sim_l2ar_cnt: got err=%0d evt=%0d want 2/1", l2_err_cnt, evt_cnt); end
    cyc(2);
  endtask

  task automatic test_spurious;
    pulse(5'b10000);
    cyc(9);
    pulse(5'b10000);
    n_cmp++; if ({l0_out, spur_cnt} !== {1'b0, 16'd2}) begin n_bad++; $display("FAIL spur_l0_wait: got out=%b spur=%0d want 0/2", l0_out, spur_cnt); end
    cyc(39);
    pulse(5'b01000);
    n_cmp++; if (l1_err_cnt !== 16'd3) begin n_bad++; $display("FAIL spur_l1_err: got %0d want 3", l1_err_cnt); end
    ext_busy = 1'b1;
    pulse(5'b10000);
    n_cmp++; if ({l0_out, trig_busy, spur_cnt} !== {2'b01, 16'd3}) begin n_bad++; $display("FAIL spur_busy_l0: got %b/%0d want 01/3", {l0_out, trig_busy}, spur_cnt); end
    ext_busy = 1'b0;
    pulse(5'b00100);
    n_cmp++; if ({l2a_out, trig_busy, spur_cnt} !== {2'b00, 16'd4}) begin n_bad++; $display("FAIL spur_idle_l2a: got %b/%0d want 00/4", {l2a_out, trig_busy}, spur_cnt); end
    cyc(2);
  endtask

  task automatic test_evt_wrap;
    force dut.evt_cnt_q = 24'hFFFFFF;
    cyc(1);
    release dut.evt_cnt_q;
    cyc(1);
    n_cmp++; if (evt_cnt !== 24'hFFFFFF) begin n_bad++; $display("FAIL wrap_preload: got %h want ffffff", evt_cnt); end
    pulse(5'b10000);
    cyc(149);
    pulse(5'b01000);
    cyc(199);
    pulse(5'b00100);
    n_cmp++; if ({l2a_out, evt_cnt} !== {1'b1, 24'd0}) begin n_bad++; $display("FAIL wrap_zero: got out=%b evt=%h want 1/0", l2a_out, evt_cnt); end
    cyc(2);
    pulse(5'b10000);
    cyc(149);
    pulse(5'b01000);
    cyc(199);
    pulse(5'b00101);
    n_cmp++; if ({l2a_out, evt_cnt} !== {1'b1, 24'd1}) begin n_bad++; $display("FAIL evres_with_l2a: got out=%b evt=%0d want 1/1", l2a_out, evt_cnt); end
    cyc(2);
  endtask

  task automatic test_reset_mid;
    int l2r_seen;
    l2_tw = {16'd40, 16'd10};
    pulse(5'b10000);
    cyc(149);
    pulse(5'b01000);
    cyc(5);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    n_cmp++; if ({l0_out, l1_out, l2a_out, l2r_out, trig_busy} !== 5'b00000) begin n_bad++; $display("FAIL rmid_pulses: got %b want 00000", {l0_out, l1_out, l2a_out, l2r_out, trig_busy}); end
    n_cmp++; if ({evt_cnt, l1_err_cnt, l2_err_cnt, spur_cnt} !== 72'd0) begin n_bad++; $display("FAIL rmid_counts: got %h want 0", {evt_cnt, l1_err_cnt, l2_err_cnt, spur_cnt}); end
    l2r_seen = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (l2r_out === 1'b1) l2r_seen++;
    end
    n_cmp++; if ({l2r_seen, trig_busy, l2_err_cnt} !== {32'd0, 1'b0, 16'd0}) begin n_bad++; $display("FAIL rmid_no_l2r: got l2r=%0d busy=%b err=%0d want 0/0/0", l2r_seen, trig_busy, l2_err_cnt); end
    l2_tw = {16'd20000, 16'd200};
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_l1_early;
    test_l1_timeout;
    test_l2_timeout;
    test_window_edges;
    test_simultaneous;
    test_spurious;
    test_evt_wrap;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
